// File: rtl/busy_timer_bank_if.sv
// Request/status bundle for busy_timer_bank: per-channel start/abort requests,
// the global mode and amount, and the per-channel ack/busy/done status back.
// master drives requests (requester side), slave is the timer bank.
interface busy_timer_bank_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
);
  logic [NCH-1:0]   i_start;
  logic [NCH-1:0]   i_abort;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_amount;
  logic [NCH-1:0]   o_ack;
  logic [NCH-1:0]   o_busy;
  logic [NCH-1:0]   o_done;
  logic             o_any_busy;

  modport master (
    output i_start, i_abort, i_mode, i_amount,
    input  o_ack, o_busy, o_done, o_any_busy
  );

  modport slave (
    input  i_start, i_abort, i_mode, i_amount,
    output o_ack, o_busy, o_done, o_any_busy
  );
endinterface

// File: rtl/busy_timer_bank.sv
// Purpose: bank of NCH independent busy timers (one-shot / retriggerable / periodic).
// Latency: accept on edge N -> o_busy for cycles N+1..N+amt, o_done pulse in the cycle after.
// Backpressure: o_ack withheld while a channel is busy (except retriggerable); requester holds i_start.
// Ports:
//   i_clk, i_reset     clock and asynchronous active-high reset
//   bus.i_start/abort  per-channel start request and abort
//   bus.i_mode         00 one-shot, 01 retriggerable, 10 periodic, 11 one-shot
//   bus.i_amount       busy length sampled at accept, 0 selects DEFAULT_AMOUNT
//   bus.o_ack/busy     combinational accept strobe / counter-nonzero per channel
//   bus.o_done         registered end-of-period pulse per channel
//   bus.o_any_busy     OR of all o_busy
module busy_timer_bank #(
  parameter int NCH            = 4,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_AMOUNT = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  busy_timer_bank_if.slave     bus
);

  localparam logic [WIDTH-1:0] DEF_AMT = WIDTH'(DEFAULT_AMOUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]           amt_eff;
  logic                       mode_retrig;
  logic                       mode_periodic;
  logic [NCH-1:0]             ack;
  logic [NCH-1:0]             busy;
  logic [NCH-1:0][WIDTH-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0][WIDTH-1:0]  reload_q, reload_d;
  logic [NCH-1:0]             done_q, done_d;

  assign amt_eff       = (bus.i_amount == '0) ? DEF_AMT : bus.i_amount;
  assign mode_retrig   = (bus.i_mode == 2'b01);
  assign mode_periodic = (bus.i_mode == 2'b10);

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = '0;
    ack      = '0;
    busy     = '0;
    for (int c = 0; c < NCH; c++) begin
      busy[c] = (cnt_q[c] != '0);
      // Abort masks the start so an abort+start pair never acks.
      ack[c]  = bus.i_start[c] & ~bus.i_abort[c] & (~busy[c] | mode_retrig);

      if (bus.i_abort[c]) begin
        cnt_d[c] = '0;
      end else if (ack[c]) begin
        cnt_d[c]    = amt_eff;
        reload_d[c] = amt_eff;
      end else if ((cnt_q[c] == ONE) && mode_periodic) begin
        cnt_d[c] = reload_q[c];
      end else if (busy[c]) begin
        cnt_d[c] = cnt_q[c] - ONE;
      end

      // End of period unless this edge aborts or retriggers the channel.
      done_d[c] = (cnt_q[c] == ONE) & ~bus.i_abort[c] & ~ack[c];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      done_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // No edge accepts while reset is asserted, so the strobe is held low then.
  assign bus.o_ack      = ack & {NCH{~i_reset}};
  assign bus.o_busy     = busy;
  assign bus.o_done     = done_q;
  assign bus.o_any_busy = |busy;

endmodule

// File: tb/tb_busy_timer_bank.sv
module tb_busy_timer_bank;
  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int DEF   = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   sb_pops = 0;
  bit   sb_en   = 1'b0;

  busy_timer_bank_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  busy_timer_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_AMOUNT(DEF)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int len;
  } sb_t;

  typedef struct {
    int         ch;
    logic [1:0] mode;
    int         amount;
    int         exp_len;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  int   run_len[NCH];
  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: on each done pulse, pop the expected record and
  // compare channel and length of the busy run that preceded it.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (sb_en && bus.o_done[c]) begin
          if (sb_q.size() == 0) begin
            chk("sb_spurious_done", c, -1);
          end else begin
            mon_e = sb_q.pop_front();
            chk("sb_done_channel", c, mon_e.ch);
            chk($sformatf("sb_busy_len_ch%0d", c), run_len[c], mon_e.len);
            chk($sformatf("sb_busy_low_at_done_ch%0d", c), int'(bus.o_busy[c]), 0);
          end
          sb_pops++;
        end
        if (bus.o_ack[c]) run_len[c] = 0;
        else if (bus.o_busy[c]) run_len[c]++;
      end
    end
  end

  // Per-cycle pattern check on one channel; bit i of each pattern is cycle i.
  task automatic run_seq(input int ch, input logic [1:0] mode, input int amt,
                         input logic [31:0] st, input logic [31:0] ab,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ed, input int n, input string nm);
    bus.i_mode   = mode;
    bus.i_amount = WIDTH'(amt);
    for (int i = 0; i < n; i++) begin
      bus.i_start[ch] = st[i];
      bus.i_abort[ch] = ab[i];
      @(negedge clk);
      chk($sformatf("%s_ack_c%0d", nm, i),  int'(bus.o_ack[ch]),   int'(ea[i]));
      chk($sformatf("%s_busy_c%0d", nm, i), int'(bus.o_busy[ch]),  int'(eb[i]));
      chk($sformatf("%s_done_c%0d", nm, i), int'(bus.o_done[ch]),  int'(ed[i]));
      chk($sformatf("%s_any_c%0d", nm, i),  int'(bus.o_any_busy), int'(eb[i]));
      @(posedge clk);
      #1;
    end
    bus.i_start[ch] = 1'b0;
    bus.i_abort[ch] = 1'b0;
  endtask

  initial begin
    int p0;
    vecs[0] = '{ch: 0, mode: 2'b00, amount: 5,   exp_len: 5};
    vecs[1] = '{ch: 1, mode: 2'b11, amount: 2,   exp_len: 2};
    vecs[2] = '{ch: 2, mode: 2'b00, amount: 1,   exp_len: 1};
    vecs[3] = '{ch: 3, mode: 2'b00, amount: 0,   exp_len: DEF};
    vecs[4] = '{ch: 0, mode: 2'b00, amount: 7,   exp_len: 7};
    vecs[5] = '{ch: 1, mode: 2'b00, amount: 300, exp_len: 300};
    for (int c = 0; c < NCH; c++) run_len[c] = 0;

    // Reset state, with starts pending to show no ack during reset.
    bus.i_start  = '1;
    bus.i_abort  = '0;
    bus.i_mode   = 2'b00;
    bus.i_amount = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack",  int'(bus.o_ack),      0);
    chk("reset_busy", int'(bus.o_busy),     0);
    chk("reset_done", int'(bus.o_done),     0);
    chk("reset_any",  int'(bus.o_any_busy), 0);
    bus.i_start = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven one-shot periods checked by the scoreboard.
    sb_en = 1'b1;
    foreach (vecs[k]) begin
      bus.i_mode   = vecs[k].mode;
      bus.i_amount = WIDTH'(vecs[k].amount);
      bus.i_start[vecs[k].ch] = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", k), int'(bus.o_ack[vecs[k].ch]), 1);
      p0 = sb_pops;
      sb_q.push_back('{ch: vecs[k].ch, len: vecs[k].exp_len});
      @(posedge clk);
      #1;
      bus.i_start[vecs[k].ch] = 1'b0;
      bus.i_amount = WIDTH'(9);  // must not affect the running period
      for (int t = 0; t < vecs[k].exp_len + 10 && sb_pops == p0; t++) @(posedge clk);
      if (sb_pops == p0) chk($sformatf("vec%0d_done_timeout", k), 0, 1);
      #1;
      repeat (2) @(posedge clk);
      #1;
    end
    sb_en = 1'b0;

    // One-shot, start held while busy: re-accepted only on the idle cycle.
    run_seq(0, 2'b00, 3, 32'h1F, 32'h0, 32'h11, 32'hEE, 32'h110, 10, "oneshot_hold");
    // Retriggerable: restart at cnt==2, single done at the very end.
    run_seq(1, 2'b01, 4, 32'h9, 32'h0, 32'h9, 32'hFE, 32'h100, 10, "retrig");
    // Periodic amount 3: no ack while busy, done every 3rd cycle, abort kills pending done.
    run_seq(2, 2'b10, 3, 32'h401, 32'h200000, 32'h1, 32'h3FFFFE, 32'h92490, 26, "periodic3");
    // Periodic amount 1: done continuously high until abort.
    run_seq(3, 2'b10, 1, 32'h1, 32'h40, 32'h1, 32'h7E, 32'h7C, 9, "periodic1");

    // Async reset mid-count with abort+start on ch1.
    bus.i_mode   = 2'b00;
    bus.i_amount = WIDTH'(50);
    bus.i_start  = '1;
    @(negedge clk);
    chk("rst_seq_ack_all", int'(bus.o_ack), 15);
    @(posedge clk);
    #1;
    bus.i_start = '0;
    repeat (10) @(posedge clk);
    #1;
    bus.i_start = 4'b0011;
    bus.i_abort = 4'b0010;
    @(negedge clk);
    chk("abort_beats_start_ack", int'(bus.o_ack),      0);
    chk("rst_seq_busy_before",   int'(bus.o_busy),     15);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(bus.o_busy),     0);
    chk("async_rst_done", int'(bus.o_done),     0);
    chk("async_rst_ack",  int'(bus.o_ack),      0);
    chk("async_rst_any",  int'(bus.o_any_busy), 0);
    @(posedge clk);
    #1;
    bus.i_start = '0;
    bus.i_abort = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_busy", int'(bus.o_busy), 0);
    chk("post_rst_done", int'(bus.o_done), 0);

    chk("sb_queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
